// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction-sequencing controller.
package cpu_pkg;

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned NSEL_W = 3;
  localparam int unsigned VSEL_W = 2;

  localparam logic [OPC_W-1:0] OPC_MOVE = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;

  localparam logic [OP_W-1:0] OP_MOV  = 2'b00;
  localparam logic [OP_W-1:0] OP_MOVI = 2'b10;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP  = 2'b01;
  localparam logic [OP_W-1:0] OP_AND  = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN  = 2'b11;

  localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
  localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b100;
  localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b001;

  localparam logic [VSEL_W-1:0] VSEL_C    = 2'b00;
  localparam logic [VSEL_W-1:0] VSEL_IMM8 = 2'b01;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WR_REG = 3'd5,
    ST_WR_IMM = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOVI    = 3'd1,
    CLS_MOV     = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } instr_class_e;

endpackage

// File: rtl/instr_dec.sv
// Combinational opcode/op classifier; anything unrecognised is ILLEGAL.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [OP_W-1:0]  i_op,
  output instr_class_e     o_class
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    if (i_opcode == OPC_MOVE) begin
      case (i_op)
        OP_MOVI: o_class = CLS_MOVI;
        OP_MOV:  o_class = CLS_MOV;
        default: o_class = CLS_ILLEGAL;
      endcase
    end else if (i_opcode == OPC_ALU) begin
      case (i_op)
        OP_ADD:  o_class = CLS_ADD;
        OP_CMP:  o_class = CLS_CMP;
        OP_AND:  o_class = CLS_AND;
        default: o_class = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Moore sequencer driving register-file and datapath strobes for one
// instruction at a time; opcode/op are captured when the start strobe is taken.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [OP_W-1:0]   op,
  output logic              w,
  output logic [NSEL_W-1:0] nsel,
  output logic [VSEL_W-1:0] vsel,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel
);

  state_e           r_state;
  state_e           w_next_state;
  logic [OPC_W-1:0] r_opcode;
  logic [OP_W-1:0]  r_op;
  instr_class_e     w_class;

  instr_dec u_instr_dec (
    .i_opcode (r_opcode),
    .i_op     (r_op),
    .o_class  (w_class)
  );

  // Instruction fields are frozen at the start edge so later IR changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode <= '0;
      r_op     <= '0;
    end else if (r_state == ST_WAIT && s) begin
      r_opcode <= opcode;
      r_op     <= op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_WAIT;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT: if (s) w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (w_class)
          CLS_MOVI:                  w_next_state = ST_WR_IMM;
          CLS_ADD, CLS_CMP, CLS_AND: w_next_state = ST_GET_A;
          CLS_MOV, CLS_MVN:          w_next_state = ST_GET_B;
          default:                   w_next_state = ST_WAIT;
        endcase
      end
      ST_GET_A:  w_next_state = ST_GET_B;
      ST_GET_B:  w_next_state = ST_EXEC;
      ST_EXEC:   w_next_state = (w_class == CLS_CMP) ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: w_next_state = ST_WAIT;
      ST_WR_IMM: w_next_state = ST_WAIT;
      default:   w_next_state = ST_WAIT;
    endcase
  end

  always_comb begin
    w     = 1'b0;
    nsel  = NSEL_NONE;
    vsel  = VSEL_C;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    case (r_state)
      ST_WAIT: w = 1'b1;
      ST_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      ST_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      ST_EXEC: begin
        loadc = 1'b1;
        asel  = (w_class == CLS_MOV) || (w_class == CLS_MVN);
        loads = (w_class == CLS_CMP);
      end
      ST_WR_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      ST_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-instruction output traces from a
// vector table plus hand-written reset and start-strobe sequences.
module tb_cpu_controller;

  logic       clk;
  logic       reset_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write, loada, loadb, loadc, loads, asel, bsel;

  cpu_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s),
    .opcode  (opcode),
    .op      (op),
    .w       (w),
    .nsel    (nsel),
    .vsel    (vsel),
    .write   (write),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .asel    (asel),
    .bsel    (bsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel}
  logic [12:0] outs;
  assign outs = {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel};

  localparam logic [12:0] O_WAIT   = {1'b1, 3'b000, 2'b00, 7'b0000000};
  localparam logic [12:0] O_DEC    = {1'b0, 3'b000, 2'b00, 7'b0000000};
  localparam logic [12:0] O_GETA   = {1'b0, 3'b100, 2'b00, 7'b0100000};
  localparam logic [12:0] O_GETB   = {1'b0, 3'b001, 2'b00, 7'b0010000};
  localparam logic [12:0] O_EX_ALU = {1'b0, 3'b000, 2'b00, 7'b0001000};
  localparam logic [12:0] O_EX_CMP = {1'b0, 3'b000, 2'b00, 7'b0001100};
  localparam logic [12:0] O_EX_MOV = {1'b0, 3'b000, 2'b00, 7'b0001010};
  localparam logic [12:0] O_WRREG  = {1'b0, 3'b010, 2'b00, 7'b1000000};
  localparam logic [12:0] O_WRIMM  = {1'b0, 3'b100, 2'b01, 7'b1000000};

  typedef struct {
    string       name;
    logic [2:0]  opc;
    logic [1:0]  opv;
    int          lat;
    logic [12:0] seq [6];
  } vec_t;

  int n_checks;
  int n_fail;
  vec_t vecs [10];

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] opc, input logic [1:0] opv,
                              input int lat, input logic [12:0] s0, input logic [12:0] s1,
                              input logic [12:0] s2, input logic [12:0] s3,
                              input logic [12:0] s4, input logic [12:0] s5);
    vec_t v;
    v.name = name; v.opc = opc; v.opv = opv; v.lat = lat;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
    v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    s        = 1'b0;
    opcode   = 3'b000;
    op       = 2'b00;

    vecs[0] = mk("movi", 3'b110, 2'b10, 3, O_DEC, O_WRIMM, O_WAIT, O_WAIT, O_WAIT, O_WAIT);
    vecs[1] = mk("mov",  3'b110, 2'b00, 5, O_DEC, O_GETB, O_EX_MOV, O_WRREG, O_WAIT, O_WAIT);
    vecs[2] = mk("add",  3'b101, 2'b00, 6, O_DEC, O_GETA, O_GETB, O_EX_ALU, O_WRREG, O_WAIT);
    vecs[3] = mk("cmp",  3'b101, 2'b01, 5, O_DEC, O_GETA, O_GETB, O_EX_CMP, O_WAIT, O_WAIT);
    vecs[4] = mk("and",  3'b101, 2'b10, 6, O_DEC, O_GETA, O_GETB, O_EX_ALU, O_WRREG, O_WAIT);
    vecs[5] = mk("mvn",  3'b101, 2'b11, 5, O_DEC, O_GETB, O_EX_MOV, O_WRREG, O_WAIT, O_WAIT);
    vecs[6] = mk("ill111_00", 3'b111, 2'b00, 2, O_DEC, O_WAIT, O_WAIT, O_WAIT, O_WAIT, O_WAIT);
    vecs[7] = mk("ill110_01", 3'b110, 2'b01, 2, O_DEC, O_WAIT, O_WAIT, O_WAIT, O_WAIT, O_WAIT);
    vecs[8] = mk("ill110_11", 3'b110, 2'b11, 2, O_DEC, O_WAIT, O_WAIT, O_WAIT, O_WAIT, O_WAIT);
    vecs[9] = mk("ill000_00", 3'b000, 2'b00, 2, O_DEC, O_WAIT, O_WAIT, O_WAIT, O_WAIT, O_WAIT);

    // Reset state, both asynchronously and across an edge
    #1;
    check("reset_async", outs, O_WAIT);
    tick();
    check("reset_held", outs, O_WAIT);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", outs, O_WAIT);

    // Table: after the start edge the IR is rewritten to MOVI, which must not matter
    for (int i = 0; i < 10; i++) begin
      opcode = vecs[i].opc;
      op     = vecs[i].opv;
      s      = 1'b1;
      check($sformatf("%s_pre", vecs[i].name), outs, O_WAIT);
      for (int k = 0; k < vecs[i].lat; k++) begin
        tick();
        if (k == 0) begin
          s      = 1'b0;
          opcode = 3'b110;
          op     = 2'b10;
        end
        check($sformatf("%s_cyc%0d", vecs[i].name, k + 1), outs, vecs[i].seq[k]);
      end
      tick();
      check($sformatf("%s_idle", vecs[i].name), outs, O_WAIT);
    end

    // s held high: WAIT lasts exactly one cycle between back-to-back MOVIs
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    tick(); check("hold_s_dec1", outs, O_DEC);
    tick(); check("hold_s_wrimm1", outs, O_WRIMM);
    tick(); check("hold_s_wait", outs, O_WAIT);
    tick(); check("hold_s_dec2", outs, O_DEC);
    s = 1'b0;
    tick(); check("hold_s_wrimm2", outs, O_WRIMM);
    tick(); check("hold_s_wait2", outs, O_WAIT);

    // s pulsed mid-CMP is ignored and not queued
    opcode = 3'b101; op = 2'b01; s = 1'b1;
    tick(); s = 1'b0; check("ign_dec", outs, O_DEC);
    tick(); s = 1'b1; check("ign_geta", outs, O_GETA);
    tick(); s = 1'b0; check("ign_getb", outs, O_GETB);
    tick(); check("ign_exec", outs, O_EX_CMP);
    tick(); check("ign_wait", outs, O_WAIT);
    tick(); check("ign_no_queue", outs, O_WAIT);

    // Reset asserted during EXEC of ADD aborts with no write
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    tick(); s = 1'b0; check("rst_dec", outs, O_DEC);
    tick(); check("rst_geta", outs, O_GETA);
    tick(); check("rst_getb", outs, O_GETB);
    tick(); check("rst_exec", outs, O_EX_ALU);
    reset_n = 1'b0;
    #1;
    check("rst_immediate", outs, O_WAIT);
    tick(); check("rst_low_edge", outs, O_WAIT);
    reset_n = 1'b1;
    tick(); check("rst_no_write", outs, O_WAIT);
    tick(); check("rst_still_idle", outs, O_WAIT);
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    tick(); s = 1'b0; check("rst_movi_dec", outs, O_DEC);
    tick(); check("rst_movi_wrimm", outs, O_WRIMM);
    tick(); check("rst_movi_wait", outs, O_WAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against write and loads ever coinciding
  always @(negedge clk) begin
    if (reset_n && write && loads) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_loads_overlap: got write=%b loads=%b expected not both 1", write, loads);
    end
  end

endmodule
